// File: rtl/c17_pipe_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | c17_pipe_sched_pkg : shared widths, tag type, c17 bit positions      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package c17_pipe_sched_pkg;

  localparam int VEC_W = 5;
  localparam int RES_W = 2;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Vector layout {N1,N2,N3,N6,N7}, result layout {N22,N23}
  localparam int N1_B  = 4;
  localparam int N2_B  = 3;
  localparam int N3_B  = 2;
  localparam int N6_B  = 1;
  localparam int N7_B  = 0;
  localparam int N22_B = 1;
  localparam int N23_B = 0;

endpackage
`default_nettype wire

// File: rtl/c17_pipe_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | c17_pipe_sched_if : requester, core and response signal bundle       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface c17_pipe_sched_if
  import c17_pipe_sched_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             en;
  logic             req0_valid;
  logic [VEC_W-1:0] req0_vec;
  logic             req0_ready;
  logic             req1_valid;
  logic [VEC_W-1:0] req1_vec;
  logic             req1_ready;
  logic [VEC_W-1:0] core_in;
  logic [RES_W-1:0] core_out;
  logic             rsp0_valid;
  logic [RES_W-1:0] rsp0_data;
  logic             rsp1_valid;
  logic [RES_W-1:0] rsp1_data;
  logic [CNT_W-1:0] issued_cnt;

  modport master (
    output en, req0_valid, req0_vec, req1_valid, req1_vec, core_out,
    input  req0_ready, req1_ready, core_in,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, issued_cnt
  );

  modport slave (
    input  en, req0_valid, req0_vec, req1_valid, req1_vec, core_out,
    output req0_ready, req1_ready, core_in,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, issued_cnt
  );

endinterface
`default_nettype wire

// File: rtl/c17_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | c17_rr_arb2 : two-way round-robin arbiter, pointer moves on grant    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module c17_rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] elig,
  input  wire logic       advance,
  output logic      [1:0] grant
);

  // prio = 1 means requester 1 wins a tie
  logic prio;

  assign grant[0] = elig[0] & (~elig[1] | ~prio);
  assign grant[1] = elig[1] & (~elig[0] |  prio);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/c17_pipe_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | c17_pipe_sched : shares one pipelined c17 core between two requesters|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module c17_pipe_sched
  import c17_pipe_sched_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input wire logic         clk,
  input wire logic         rst,
  c17_pipe_sched_if.slave  bus
);

  localparam int OUT_W = 4;

  logic [1:0]       req_valid;
  logic [VEC_W-1:0] req_vec [2];
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       retire;
  logic             any_grant;

  // tag[0] rides alongside core_in, tag[k] alongside core stage k
  tag_t             tag [LATENCY+1];

  logic [VEC_W-1:0] core_in_q;
  logic             rsp0_valid_q;
  logic [RES_W-1:0] rsp0_data_q;
  logic             rsp1_valid_q;
  logic [RES_W-1:0] rsp1_data_q;
  logic [CNT_W-1:0] issued_cnt_q;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign req_vec[0] = bus.req0_vec;
  assign req_vec[1] = bus.req1_vec;
  assign any_grant  = |grant;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_req
      logic [OUT_W-1:0] out_cnt;

      assign retire[i] = tag[LATENCY].valid && (tag[LATENCY].owner == 1'(i));
      // A slot freed by a retire on this edge can be reused on the same edge
      assign elig[i]   = bus.en & req_valid[i] &
                         ((out_cnt < OUT_W'(MAX_OUT)) | retire[i]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_cnt <= '0;
        end else if (grant[i] && !retire[i]) begin
          out_cnt <= out_cnt + 1'b1;
        end else if (retire[i] && !grant[i]) begin
          out_cnt <= out_cnt - 1'b1;
        end
      end
    end
  endgenerate

  c17_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig    (elig),
    .advance (any_grant),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LATENCY; k++) begin
        tag[k] <= '0;
      end
    end else begin
      tag[0] <= any_grant ? tag_t'{valid: 1'b1, owner: grant[1]} : '0;
      for (int k = 1; k <= LATENCY; k++) begin
        tag[k] <= tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_in_q    <= '0;
      issued_cnt_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      if (any_grant) begin
        core_in_q    <= grant[1] ? req_vec[1] : req_vec[0];
        issued_cnt_q <= issued_cnt_q + 1'b1;
      end
      rsp0_valid_q <= retire[0];
      rsp1_valid_q <= retire[1];
      if (retire[0]) begin
        rsp0_data_q <= bus.core_out;
      end
      if (retire[1]) begin
        rsp1_data_q <= bus.core_out;
      end
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.core_in    = core_in_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.issued_cnt = issued_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_c17_pipe_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_c17_pipe_sched : scoreboard bench with a c17 core model           |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_c17_pipe_sched;
  import c17_pipe_sched_pkg::*;

  localparam int LAT  = 3;
  localparam int MAXO = 4;
  localparam int CW   = 16;

  typedef struct {
    logic [1:0] d;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c17_pipe_sched_if #(.CNT_W(CW)) bus ();

  c17_pipe_sched #(.LATENCY(LAT), .MAX_OUT(MAXO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [1:0] c17_ref(logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    logic [1:0] r;
    n1  = v[N1_B];
    n2  = v[N2_B];
    n3  = v[N3_B];
    n6  = v[N6_B];
    n7  = v[N7_B];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    r[N22_B] = ~(n10 & n16);
    r[N23_B] = ~(n16 & n19);
    return r;
  endfunction

  // External core: core_out reflects core_in LAT edges after it changes
  logic [1:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= c17_ref(bus.core_in);
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign bus.core_out = cpipe[LAT-1];

  int   edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  exp_t q0[$];
  exp_t q1[$];
  int   acc0[$];
  int   acc1[$];
  int   exp_cnt = 0;
  int   total   = 0;
  int   last_w  = 1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Vectors accepted at edge a occupy a credit on edges a..a+LAT; a retire
  // on edge a+LAT+1 frees the slot for an accept on that same edge.
  function automatic int inflight(int r, int e);
    int n = 0;
    if (r == 0) begin
      foreach (acc0[i]) if (acc0[i] > e - LAT - 1) n++;
    end else begin
      foreach (acc1[i]) if (acc1[i] > e - LAT - 1) n++;
    end
    return n;
  endfunction

  task automatic cycle(bit v0, logic [4:0] d0, bit v1, logic [4:0] d1, bit en);
    int e;
    bit el0, el1, g0, g1;
    @(negedge clk);
    #2;
    bus.en = en; bus.req0_valid = v0; bus.req0_vec = d0;
    bus.req1_valid = v1; bus.req1_vec = d1;
    #1;
    e = edge_n + 1;
    while (acc0.size() > 0 && acc0[0] <= e - LAT - 1) void'(acc0.pop_front());
    while (acc1.size() > 0 && acc1[0] <= e - LAT - 1) void'(acc1.pop_front());
    el0 = en && v0 && (inflight(0, e) < MAXO);
    el1 = en && v1 && (inflight(1, e) < MAXO);
    g0  = el0 && (!el1 || last_w == 1);
    g1  = el1 && (!el0 || last_w == 0);
    chk("ready0", int'(bus.req0_ready), int'(g0));
    chk("ready1", int'(bus.req1_ready), int'(g1));
    if (g0) begin
      q0.push_back('{c17_ref(d0), e + LAT + 1});
      acc0.push_back(e);
      last_w = 0;
    end
    if (g1) begin
      q1.push_back('{c17_ref(d1), e + LAT + 1});
      acc1.push_back(e);
      last_w = 1;
    end
    if (g0 || g1) begin
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      total++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.en = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    chk("rst_core_in",  int'(bus.core_in), 0);
    chk("rst_rsp0_v",   int'(bus.rsp0_valid), 0);
    chk("rst_rsp1_v",   int'(bus.rsp1_valid), 0);
    chk("rst_rsp_data", int'({bus.rsp0_data, bus.rsp1_data}), 0);
    chk("rst_cnt",      int'(bus.issued_cnt), 0);
    q0.delete(); q1.delete(); acc0.delete(); acc1.delete();
    exp_cnt = 0; total = 0; last_w = 1;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compares every presented response against the scoreboard
  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst) begin
      if (bus.rsp0_valid) begin
        if (q0.size() == 0) chk("rsp0_unexpected", int'(bus.rsp0_valid), 0);
        else begin
          x = q0.pop_front();
          chk("rsp0_data", int'(bus.rsp0_data), int'(x.d));
          chk("rsp0_edge", edge_n, x.due);
        end
      end else if (q0.size() > 0 && q0[0].due <= edge_n) begin
        chk("rsp0_missing", int'(bus.rsp0_valid), 1);
        void'(q0.pop_front());
      end
      if (bus.rsp1_valid) begin
        if (q1.size() == 0) chk("rsp1_unexpected", int'(bus.rsp1_valid), 0);
        else begin
          x = q1.pop_front();
          chk("rsp1_data", int'(bus.rsp1_data), int'(x.d));
          chk("rsp1_edge", edge_n, x.due);
        end
      end else if (q1.size() > 0 && q1[0].due <= edge_n) begin
        chk("rsp1_missing", int'(bus.rsp1_valid), 1);
        void'(q1.pop_front());
      end
      chk("issued_cnt", int'(bus.issued_cnt), exp_cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.req0_valid = 1'b0; bus.req0_vec = '0;
    bus.req1_valid = 1'b0; bus.req1_vec = '0;
    do_reset();

    cycle(1'b1, 5'b10101, 1'b0, 5'd0, 1'b1);
    idle(6);

    repeat (8) cycle(1'b1, 5'b11110, 1'b1, 5'b01111, 1'b1);
    idle(6);

    repeat (6) cycle(1'b1, 5'($urandom), 1'b0, 5'd0, 1'b1);
    idle(6);

    repeat (3) cycle(1'b1, 5'($urandom), 1'b0, 5'd0, 1'b1);
    repeat (2) cycle(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b0);
    idle(6);

    repeat (3) cycle(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1);
    do_reset();
    idle(6);
    cycle(1'b0, 5'd0, 1'b1, 5'b10011, 1'b1);
    idle(6);

    repeat (400)
      cycle(1'($urandom_range(0, 1)), 5'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom),
            ($urandom_range(0, 3) != 0));
    idle(6);

    while (total < (1 << CW) + 4)
      cycle(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1);
    idle(8);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
